// File: rtl/pipeline_stall_controller.sv
// Five-stage pipeline stall/flush controller: RAW hazards, taken branches,
// SRAM wait states with timeout, and a debug halt that drains EXE/MEM/WB first.
module pipeline_stall_controller #(
   parameter int MEM_TIMEOUT  = 255,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             pc_freeze,
   output logic             ifid_freeze,
   output logic             ifid_flush,
   output logic             idexe_flush,
   output logic             pipe_freeze,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MEM_WAIT = 3'd1,
      DRAIN    = 3'd2,
      HALTED   = 3'd3,
      TIMEOUT  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             halted_q, terr_q;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             mem_stall;

   assign mem_stall = mem_req && !mem_ready;

   always_comb begin
      pc_freeze   = 1'b0;
      ifid_freeze = 1'b0;
      ifid_flush  = 1'b0;
      idexe_flush = 1'b0;
      pipe_freeze = 1'b0;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (branch_taken) begin
               ifid_flush  = 1'b1;
               idexe_flush = 1'b1;
            end else if (hazard) begin
               pc_freeze   = 1'b1;
               ifid_freeze = 1'b1;
               idexe_flush = 1'b1;
            end
         end
         DRAIN: begin
            // Bubbles keep flowing into EXE; a late branch still redirects fetch.
            pc_freeze   = !branch_taken;
            ifid_freeze = 1'b1;
            ifid_flush  = branch_taken;
            idexe_flush = 1'b1;
         end
         default: begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            pipe_freeze = 1'b1;
         end
      endcase
      if (mem_stall) begin
         pc_freeze   = 1'b1;
         ifid_freeze = 1'b1;
         pipe_freeze = 1'b1;
         ifid_flush  = 1'b0;
         idexe_flush = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      drain_d = drain_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               wait_d  = '0;
            end else if (halt_req && !branch_taken) begin
               state_d = DRAIN;
               drain_d = DW'(DRAIN_CYCLES);
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               wait_d = wait_q + 1'b1;
               if (wait_q == WW'(MEM_TIMEOUT - 1)) state_d = TIMEOUT;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (!halt_req) begin
               state_d = RUN;
            end else if (!pipe_freeze) begin
               drain_d = drain_q - 1'b1;
               if (drain_q == DW'(1)) state_d = HALTED;
            end
         end
         HALTED: begin
            if (!halt_req) state_d = RUN;
         end
         default: state_d = TIMEOUT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         wait_q   <= '0;
         drain_q  <= '0;
         halted_q <= 1'b0;
         terr_q   <= 1'b0;
         stall_q  <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         drain_q  <= drain_d;
         halted_q <= (state_d == HALTED);
         terr_q   <= terr_q || (state_d == TIMEOUT);
         if (pc_freeze && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
         if (ifid_flush && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
      end
   end

   assign halted      = halted_q;
   assign timeout_err = terr_q;
   assign stall_cnt   = stall_q;
   assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: default instance plus a
// MEM_TIMEOUT=4, CNT_W=3 instance for timeout and counter saturation.
module tb_pipeline_stall_controller;

   logic clk = 1'b0;
   logic rst, hazard, branch_taken, mem_req, mem_ready, halt_req;

   logic        pc_freeze, ifid_freeze, ifid_flush, idexe_flush, pipe_freeze;
   logic        halted, timeout_err;
   logic [15:0] stall_cnt, flush_cnt;

   logic        t_pc, t_ifz, t_ifl, t_idfl, t_pipe, t_halted, t_terr;
   logic [2:0]  t_stall, t_flush;

   int n_tests = 0;
   int n_fail  = 0;

   // {pc_freeze, ifid_freeze, ifid_flush, idexe_flush, pipe_freeze}
   wire [4:0] ctl   = {pc_freeze, ifid_freeze, ifid_flush, idexe_flush, pipe_freeze};
   wire [4:0] t_ctl = {t_pc, t_ifz, t_ifl, t_idfl, t_pipe};

   always #5 clk = ~clk;

   pipeline_stall_controller #(.MEM_TIMEOUT(255), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
      .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
      .idexe_flush(idexe_flush), .pipe_freeze(pipe_freeze), .halted(halted),
      .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_stall_controller #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(3), .CNT_W(3)) u_to (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
      .pc_freeze(t_pc), .ifid_freeze(t_ifz), .ifid_flush(t_ifl),
      .idexe_flush(t_idfl), .pipe_freeze(t_pipe), .halted(t_halted),
      .timeout_err(t_terr), .stall_cnt(t_stall), .flush_cnt(t_flush)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hazard = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      n_tests++;
      if (ctl !== 5'b00000 || halted !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: ctl=%b halted=%b terr=%b, want ctl=00000 halted=0 terr=0", ctl, halted, timeout_err);
      end
      n_tests++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_counters: stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
      end
      hazard = 1;
      #1;
      n_tests++;
      if (ctl !== 5'b11010) begin
         n_fail++;
         $display("FAIL reset_run_rules: ctl=%b want 11010", ctl);
      end
      tick();
      n_tests++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_holds_cnt: stall=%0d want 0", stall_cnt);
      end
      rst = 0;
      idle();
   endtask

   task automatic test_hazard();
      do_reset();
      hazard = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++;
         if (ctl !== 5'b11010) begin
            n_fail++;
            $display("FAIL hazard_cycle%0d: ctl=%b want 11010", i, ctl);
         end
         tick();
      end
      hazard = 0;
      #1;
      n_tests++;
      if (ctl !== 5'b00000) begin
         n_fail++;
         $display("FAIL hazard_release: ctl=%b want 00000", ctl);
      end
      n_tests++;
      if (stall_cnt !== 16'd2 || flush_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL hazard_counts: stall=%0d flush=%0d want 2 0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_branch_over_hazard();
      hazard = 1; branch_taken = 1;
      #1;
      n_tests++;
      if (ctl !== 5'b00110) begin
         n_fail++;
         $display("FAIL branch_hazard_ctl: ctl=%b want 00110", ctl);
      end
      tick();
      idle();
      n_tests++;
      if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL branch_hazard_counts: flush=%0d stall=%0d want 1 2", flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if (ctl !== 5'b11001) begin
            n_fail++;
            $display("FAIL mem_stall_cycle%0d: ctl=%b want 11001", i, ctl);
         end
         tick();
      end
      mem_ready = 1;
      #1;
      n_tests++;
      if (ctl !== 5'b00000) begin
         n_fail++;
         $display("FAIL mem_ready_unfreeze: ctl=%b want 00000", ctl);
      end
      tick();
      idle();
      n_tests++;
      if (dut.state_q !== 3'd0 || stall_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL mem_wait_return: state=%0d stall=%0d want 0 5", dut.state_q, stall_cnt);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (t_terr !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: terr=%b want 0", t_terr);
      end
      tick();
      n_tests++;
      if (t_terr !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_entry: terr=%b want 1", t_terr);
      end
      idle();
      for (int i = 0; i < 10; i++) tick();
      n_tests++;
      if (t_terr !== 1'b1 || t_ctl !== 5'b11001) begin
         n_fail++;
         $display("FAIL timeout_sticky: terr=%b ctl=%b want 1 11001", t_terr, t_ctl);
      end
      n_tests++;
      if (t_stall !== 3'd7) begin
         n_fail++;
         $display("FAIL stall_saturate: stall=%0d want 7", t_stall);
      end
      n_tests++;
      if (timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_default: terr=%b want 0", timeout_err);
      end
      rst = 1;
      tick();
      rst = 0;
      n_tests++;
      if (t_terr !== 1'b0 || t_ctl !== 5'b00000 || t_stall !== 3'd0) begin
         n_fail++;
         $display("FAIL timeout_reset: terr=%b ctl=%b stall=%0d want 0 00000 0", t_terr, t_ctl, t_stall);
      end
   endtask

   task automatic test_drain_halt();
      do_reset();
      halt_req = 1;
      #1;
      n_tests++;
      if (ctl !== 5'b00000) begin
         n_fail++;
         $display("FAIL halt_req_run: ctl=%b want 00000", ctl);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         mem_req = (i == 1);
         #1;
         n_tests++;
         if (ctl !== ((i == 1) ? 5'b11001 : 5'b11010) || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_cycle%0d: ctl=%b halted=%b want %b 0", i, ctl, halted,
                     (i == 1) ? 5'b11001 : 5'b11010);
         end
         tick();
      end
      mem_req = 0;
      n_tests++;
      if (halted !== 1'b1 || ctl !== 5'b11001) begin
         n_fail++;
         $display("FAIL halted_entry: halted=%b ctl=%b want 1 11001", halted, ctl);
      end
      halt_req = 0;
      #1;
      n_tests++;
      if (ctl !== 5'b11001) begin
         n_fail++;
         $display("FAIL halted_release_cycle: ctl=%b want 11001", ctl);
      end
      tick();
      n_tests++;
      if (halted !== 1'b0 || ctl !== 5'b00000) begin
         n_fail++;
         $display("FAIL halt_exit: halted=%b ctl=%b want 0 00000", halted, ctl);
      end
   endtask

   task automatic test_rst_mid_drain();
      do_reset();
      halt_req = 1;
      tick();
      tick();
      rst = 1;
      tick();
      n_tests++;
      if (dut.state_q !== 3'd0 || dut.drain_q !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_mid_drain: state=%0d drain=%0d stall=%0d flush=%0d want 0 0 0 0",
                  dut.state_q, dut.drain_q, stall_cnt, flush_cnt);
      end
      n_tests++;
      if (ctl !== 5'b00000) begin
         n_fail++;
         $display("FAIL rst_run_ctl: ctl=%b want 00000", ctl);
      end
      rst = 0;
      tick();
      n_tests++;
      if (dut.state_q !== 3'd2 || ctl !== 5'b11010) begin
         n_fail++;
         $display("FAIL drain_reentry: state=%0d ctl=%b want 2 11010", dut.state_q, ctl);
      end
      branch_taken = 1;
      #1;
      n_tests++;
      if (ctl !== 5'b01110) begin
         n_fail++;
         $display("FAIL drain_branch: ctl=%b want 01110", ctl);
      end
      tick();
      branch_taken = 0;
      halt_req = 0;
      tick();
      n_tests++;
      if (dut.state_q !== 3'd0 || ctl !== 5'b00000 || flush_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL drain_abort: state=%0d ctl=%b flush=%0d want 0 00000 1", dut.state_q, ctl, flush_cnt);
      end
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_hazard();
      test_branch_over_hazard();
      test_mem_wait();
      test_timeout();
      test_drain_halt();
      test_rst_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
